// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with optional memory-ready stalls, optional full
// branch decode, illegal-instruction trapping and a retired-instruction counter.
module multicycle_control_unit #(
   parameter bit MEM_WAIT    = 1'b1,
   parameter bit BRANCH_FULL = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       Op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             Zero,
   input  logic             Lt,
   input  logic             Ltu,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             illegal,
   output logic             instr_done,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] instret_r;
   logic             rdy_s;
   logic             alu_f3_ok_s;
   logic             legal_s;
   logic             take_s;
   logic [2:0]       alu_r_s;
   logic [2:0]       alu_i_s;
   logic             pcw_s, adr_s, irw_s, mw_s, rw_s, ill_s, done_s;
   logic [1:0]       rs_s, sa_s, sb_s;
   logic [2:0]       alu_s;

   // A disabled handshake makes every memory access complete immediately.
   assign rdy_s = mem_ready | ~MEM_WAIT;

   // Instruction legality, ALU operation decode and branch condition.
   always_comb begin
      alu_f3_ok_s = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
      case (Op)
         OP_LW, OP_SW, OP_JAL: legal_s = 1'b1;
         OP_R:   legal_s = alu_f3_ok_s &&
                           ((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
         OP_I:   legal_s = alu_f3_ok_s;
         OP_BR: begin
            if (BRANCH_FULL) begin
               legal_s = (funct3 != 3'b010) && (funct3 != 3'b011);
            end else begin
               legal_s = (funct3 == 3'b000);
            end
         end
         default: legal_s = 1'b0;
      endcase
      case (funct3)
         3'b010:  alu_i_s = ALU_SLT;
         3'b110:  alu_i_s = ALU_OR;
         3'b111:  alu_i_s = ALU_AND;
         default: alu_i_s = ALU_ADD;
      endcase
      if ((funct3 == 3'b000) && funct7[5]) begin
         alu_r_s = ALU_SUB;
      end else begin
         alu_r_s = alu_i_s;
      end
      case (funct3)
         3'b000:  take_s = Zero;
         3'b001:  take_s = ~Zero;
         3'b100:  take_s = Lt;
         3'b101:  take_s = ~Lt;
         3'b110:  take_s = Ltu;
         3'b111:  take_s = ~Ltu;
         default: take_s = 1'b0;
      endcase
   end

   // Immediate format follows the opcode directly, independent of state.
   always_comb begin
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Per-state datapath controls; rdy and take are the only input-dependent terms.
   always_comb begin
      pcw_s  = 1'b0;
      adr_s  = 1'b0;
      irw_s  = 1'b0;
      mw_s   = 1'b0;
      rw_s   = 1'b0;
      ill_s  = 1'b0;
      done_s = 1'b0;
      rs_s   = 2'b00;
      sa_s   = 2'b00;
      sb_s   = 2'b00;
      alu_s  = ALU_ADD;
      case (state_r)
         S_FETCH: begin
            irw_s = rdy_s;
            pcw_s = rdy_s;
            sb_s  = 2'b10;
            rs_s  = 2'b10;
         end
         S_DECODE: begin
            sa_s = 2'b01;
            sb_s = 2'b01;
         end
         S_MEMADR: begin
            sa_s = 2'b10;
            sb_s = 2'b01;
         end
         S_MEMREAD:  adr_s = 1'b1;
         S_MEMWB: begin
            rs_s = 2'b01;
            rw_s = 1'b1;
            done_s = 1'b1;
         end
         S_MEMWRITE: begin
            adr_s  = 1'b1;
            mw_s   = 1'b1;
            done_s = rdy_s;
         end
         S_EXECR: begin
            sa_s  = 2'b10;
            alu_s = alu_r_s;
         end
         S_EXECI: begin
            sa_s  = 2'b10;
            sb_s  = 2'b01;
            alu_s = alu_i_s;
         end
         S_ALUWB: begin
            rw_s   = 1'b1;
            done_s = 1'b1;
         end
         S_JAL: begin
            sa_s  = 2'b01;
            sb_s  = 2'b10;
            pcw_s = 1'b1;
         end
         S_BRANCH: begin
            sa_s   = 2'b10;
            alu_s  = ALU_SUB;
            pcw_s  = take_s;
            done_s = 1'b1;
         end
         S_TRAP:  ill_s = 1'b1;
         default: ill_s = 1'b0;
      endcase
   end

   // Strobes are suppressed while reset is held so no write escapes a reset.
   assign PCWrite    = pcw_s & ~rst;
   assign IRWrite    = irw_s & ~rst;
   assign MemWrite   = mw_s & ~rst;
   assign RegWrite   = rw_s & ~rst;
   assign instr_done = done_s & ~rst;
   assign illegal    = ill_s & ~rst;
   assign AdrSrc     = adr_s;
   assign ResultSrc  = rs_s;
   assign ALUSrcA    = sa_s;
   assign ALUSrcB    = sb_s;
   assign ALUControl = alu_s;
   assign instret    = instret_r;

   // State sequencing and retired-instruction counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_FETCH;
         instret_r <= {CNT_W{1'b0}};
      end else begin
         if (done_s) begin
            instret_r <= instret_r + CNT_W'(1'b1);
         end
         case (state_r)
            S_FETCH:   if (rdy_s) state_r <= S_DECODE;
            S_DECODE: begin
               if (!legal_s) begin
                  state_r <= S_TRAP;
               end else begin
                  case (Op)
                     OP_LW, OP_SW: state_r <= S_MEMADR;
                     OP_R:         state_r <= S_EXECR;
                     OP_I:         state_r <= S_EXECI;
                     OP_BR:        state_r <= S_BRANCH;
                     OP_JAL:       state_r <= S_JAL;
                     default:      state_r <= S_TRAP;
                  endcase
               end
            end
            S_MEMADR:   state_r <= (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy_s) state_r <= S_MEMWB;
            S_MEMWB:    state_r <= S_FETCH;
            S_MEMWRITE: if (rdy_s) state_r <= S_FETCH;
            S_EXECR:    state_r <= S_ALUWB;
            S_EXECI:    state_r <= S_ALUWB;
            S_ALUWB:    state_r <= S_FETCH;
            S_JAL:      state_r <= S_ALUWB;
            S_BRANCH:   state_r <= S_FETCH;
            S_TRAP:     state_r <= S_TRAP;
            default:    state_r <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a full-featured instance with the
// memory handshake enabled, and a reduced instance (beq only, no handshake,
// 4-bit counter) held in reset until its own scenarios.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst2 = 1'b1;
   logic [6:0] Op = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic [6:0] funct7 = 7'b0000000;
   logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
   logic       mem_ready = 1'b1;

   logic PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal, instr_done;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [31:0] instret;

   logic PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, illegal2, instr_done2;
   logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
   logic [2:0] ALUControl2;
   logic [3:0] instret2;

   logic [15:0] ctrl, ctrl2;
   int checks = 0;
   int errors = 0;

   logic [15:0] e_fetch, e_fetch_stall, e_decode, e_exr_add, e_exr_sub, e_aluwb;
   logic [15:0] e_memadr, e_memrd, e_memwb, e_memwr_wait, e_memwr_done;
   logic [15:0] e_exi_add, e_jal, e_trap;

   always #5 clk = ~clk;

   assign ctrl  = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUControl, illegal, instr_done};
   assign ctrl2 = {PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, ResultSrc2,
                   ALUSrcA2, ALUSrcB2, ALUControl2, illegal2, instr_done2};

   multicycle_control_unit #(.MEM_WAIT(1'b1), .BRANCH_FULL(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .illegal(illegal), .instr_done(instr_done), .instret(instret));

   multicycle_control_unit #(.MEM_WAIT(1'b0), .BRANCH_FULL(1'b0), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst2), .Op(Op), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .IRWrite(IRWrite2), .MemWrite(MemWrite2),
      .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
      .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
      .illegal(illegal2), .instr_done(instr_done2), .instret(instret2));

   // Packs one expected control word in the same field order as ctrl.
   function automatic logic [15:0] ev(input logic pcw, adr, irw, mw, rw,
                                      input logic [1:0] rs, sa, sb,
                                      input logic [2:0] alu, input logic ill, done);
      return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, ill, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_enables got %b exp 00000",
                  {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (instret !== 32'd0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state instret %0d illegal %b exp 0 0", instret, illegal);
      end
   endtask

   task automatic test_add_sub(input logic sub, input logic [31:0] exp_cnt);
      logic [15:0] exp_q [4];
      exp_q = '{e_fetch, e_decode, sub ? e_exr_sub : e_exr_add, e_aluwb};
      Op = 7'b0110011; funct3 = 3'b000; funct7 = sub ? 7'b0100000 : 7'b0000000;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ctrl !== exp_q[i]) begin
            errors++;
            $display("FAIL rtype_sub%0d_cyc%0d ctrl got %h exp %h", sub, i, ctrl, exp_q[i]);
         end
         tick();
      end
      checks++;
      if (instret !== exp_cnt || ImmSrc !== 2'b00) begin
         errors++;
         $display("FAIL rtype_count instret %0d imm %b exp %0d 00", instret, ImmSrc, exp_cnt);
      end
   endtask

   task automatic test_lw_wait();
      logic [15:0] exp_q [7];
      logic        rdy_q [7];
      exp_q = '{e_fetch, e_decode, e_memadr, e_memrd, e_memrd, e_memrd, e_memwb};
      rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      Op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy_q[i];
         @(negedge clk);
         checks++;
         if (ctrl !== exp_q[i] || ImmSrc !== 2'b00) begin
            errors++;
            $display("FAIL lw_cyc%0d ctrl got %h imm %b exp %h 00", i, ctrl, ImmSrc, exp_q[i]);
         end
         tick();
      end
      mem_ready = 1'b1;
      checks++;
      if (instret !== 32'd3) begin
         errors++;
         $display("FAIL lw_count instret got %0d exp 3", instret);
      end
   endtask

   task automatic test_sw_wait();
      logic [15:0] exp_q [8];
      logic        rdy_q [8];
      int          mw_cnt = 0;
      int          done_cnt = 0;
      exp_q = '{e_fetch_stall, e_fetch, e_decode, e_memadr,
                e_memwr_wait, e_memwr_wait, e_memwr_wait, e_memwr_done};
      rdy_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      Op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy_q[i];
         @(negedge clk);
         checks++;
         if (ctrl !== exp_q[i] || ImmSrc !== 2'b01) begin
            errors++;
            $display("FAIL sw_cyc%0d ctrl got %h imm %b exp %h 01", i, ctrl, ImmSrc, exp_q[i]);
         end
         if (MemWrite === 1'b1) mw_cnt++;
         if (instr_done === 1'b1) done_cnt++;
         tick();
      end
      mem_ready = 1'b1;
      checks++;
      if (mw_cnt != 4 || done_cnt != 1 || instret !== 32'd4) begin
         errors++;
         $display("FAIL sw_summary memwrite %0d done %0d instret %0d exp 4 1 4",
                  mw_cnt, done_cnt, instret);
      end
   endtask

   task automatic test_branch_sweep();
      logic [2:0] f3_q [6];
      logic       take;
      logic [15:0] exp_v;
      f3_q = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      Op = 7'b1100011; funct7 = 7'b0000000; mem_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         for (int f = 0; f < 8; f++) begin
            funct3 = f3_q[b];
            {Zero, Lt, Ltu} = 3'(f);
            case (f3_q[b])
               3'b000:  take = Zero;
               3'b001:  take = !Zero;
               3'b100:  take = Lt;
               3'b101:  take = !Lt;
               3'b110:  take = Ltu;
               default: take = !Ltu;
            endcase
            exp_v = ev(take, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b1);
            tick();
            tick();
            @(negedge clk);
            checks++;
            if (ctrl !== exp_v || ImmSrc !== 2'b10) begin
               errors++;
               $display("FAIL branch_f3_%b_zlu_%b ctrl got %h imm %b exp %h 10",
                        funct3, {Zero, Lt, Ltu}, ctrl, ImmSrc, exp_v);
            end
            tick();
         end
      end
      checks++;
      if (instret !== 32'd52) begin
         errors++;
         $display("FAIL branch_count instret got %0d exp 52", instret);
      end
   endtask

   task automatic test_reset_mid();
      Op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000; mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b0 || instr_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_write memwrite %b done %b exp 0 0", MemWrite, instr_done);
      end
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
   endtask

   task automatic test_trap();
      logic [6:0] op_q [2];
      logic [2:0] f3_q [2];
      logic [6:0] f7_q [2];
      logic [31:0] cnt_exp = 32'd0;
      op_q = '{7'b0110111, 7'b0110011};
      f3_q = '{3'b000, 3'b010};
      f7_q = '{7'b0000000, 7'b0100000};
      mem_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         Op = op_q[v]; funct3 = f3_q[v]; funct7 = f7_q[v];
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl !== ((i == 0) ? e_fetch : (i == 1) ? e_decode : e_trap)) begin
               errors++;
               $display("FAIL trap%0d_cyc%0d ctrl got %h", v, i, ctrl);
            end
            tick();
         end
         checks++;
         if (instret !== cnt_exp) begin
            errors++;
            $display("FAIL trap%0d_count instret got %0d exp %0d", v, instret, cnt_exp);
         end
         rst = 1'b1;
         tick();
         rst = 1'b0;
         #1;
         checks++;
         if (illegal !== 1'b0 || ctrl !== e_fetch) begin
            errors++;
            $display("FAIL trap%0d_release illegal %b ctrl %h exp 0 %h", v, illegal, ctrl, e_fetch);
         end
      end
   endtask

   task automatic test_nofull_bne();
      Op = 7'b1100011; funct3 = 3'b001; funct7 = 7'b0000000; mem_ready = 1'b0;
      rst2 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (ctrl2 !== ((i == 0) ? e_fetch : (i == 1) ? e_decode : e_trap)) begin
            errors++;
            $display("FAIL nofull_bne_cyc%0d ctrl got %h", i, ctrl2);
         end
         tick();
      end
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      mem_ready = 1'b1;
   endtask

   task automatic test_wrap_jal();
      logic [15:0] exp_q [4];
      Op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
      for (int n = 1; n <= 17; n++) begin
         tick();
         tick();
         @(negedge clk);
         checks++;
         if (ctrl2 !== e_exi_add) begin
            errors++;
            $display("FAIL addi%0d_exec ctrl got %h exp %h", n, ctrl2, e_exi_add);
         end
         tick();
         tick();
         if (n >= 16) begin
            checks++;
            if (instret2 !== ((n == 16) ? 4'd0 : 4'd1)) begin
               errors++;
               $display("FAIL wrap_after%0d instret got %0d exp %0d", n, instret2, (n == 16) ? 0 : 1);
            end
         end
      end
      exp_q = '{e_fetch, e_decode, e_jal, e_aluwb};
      Op = 7'b1101111; funct3 = 3'b000; funct7 = 7'b0000000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ctrl2 !== exp_q[i] || ImmSrc2 !== 2'b11) begin
            errors++;
            $display("FAIL jal_cyc%0d ctrl got %h imm %b exp %h 11", i, ctrl2, ImmSrc2, exp_q[i]);
         end
         tick();
      end
      checks++;
      if (instret2 !== 4'd2) begin
         errors++;
         $display("FAIL jal_count instret got %0d exp 2", instret2);
      end
   endtask

   // Builds the expected control words, then runs every scenario in order.
   initial begin
      e_fetch       = ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
      e_fetch_stall = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
      e_decode      = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0);
      e_exr_add     = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
      e_exr_sub     = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0);
      e_aluwb       = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      e_memadr      = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0);
      e_memrd       = ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      e_memwb       = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      e_memwr_wait  = ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
      e_memwr_done  = ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      e_exi_add     = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0);
      e_jal         = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0);
      e_trap        = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);

      test_reset();
      test_add_sub(1'b0, 32'd1);
      test_add_sub(1'b1, 32'd2);
      test_lw_wait();
      test_sw_wait();
      test_branch_sweep();
      test_reset_mid();
      test_trap();
      test_nofull_bne();
      test_wrap_jal();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle successor to the single-cycle control unit. It sequences each RV32I instruction through a Moore FSM and drives datapath selects and write enables for a shared-memory multicycle datapath. It supports an optional memory-ready handshake and optional full branch-condition support. It also provides illegal-instruction trapping and a retired-instruction counter. The block sits between the instruction register/ALU flags and the multicycle datapath.

## Interface

- MEM_WAIT, 1, when 1 FETCH/MEMREAD/MEMWRITE stall until mem_ready=1; when 0 mem_ready is ignored (treated as 1).
- BRANCH_FULL, 1, when 1 decodes beq/bne/blt/bge/bltu/bgeu; when 0 only beq is legal.
- CNT_W, 32, width of instret counter.

Ports:

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  7  opcode from instruction register.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed SrcA < SrcB.
- Ltu  in  1  unsigned SrcA < SrcB.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 Result.
- IRWrite  out  1  instruction/OldPC register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1 register.
- ALUSrcB  out  2  00 RD2 register, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  high while in TRAP.
- instr_done  out  1  1-cycle pulse on last cycle of each instruction.
- instret  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W.

## Operation

- Legal opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal. All other opcodes are illegal.
- Legal ALU funct3 values: 000 add/sub, 010 slt, 110 or, 111 and. Any other funct3 is illegal.
- R-type with funct7=0100000 is legal only when funct3=000 (sub). Any funct7 other than 0000000 or 0100000 is illegal.
- Legal branch funct3: with BRANCH_FULL=1, 000, 001, 100, 101, 110, 111; with BRANCH_FULL=0, only 000.
- ImmSrc is combinational on Op: lw/I-ALU 00, sw 01, branch 10, jal 11, others 00.
- Unlisted outputs in each state are 0; ALUControl defaults to add.
- FSM states and outputs:
  - FETCH: AdrSrc=0, IRWrite=rdy, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=rdy, where rdy = mem_ready | ~MEM_WAIT. Stays in FETCH while !rdy, else goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add. Goes to TRAP if illegal, else MEMADR (lw/sw), EXECUTER, EXECUTEI, BRANCH, or JAL.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB when rdy, else holds.
  - MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held for every wait cycle. Goes to FETCH when rdy.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00. ALUControl decoded from funct3/funct7[5]. Goes to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01. ALUControl decoded from funct3, with funct7 ignored (addi is never sub). Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=take. Goes to FETCH.
  - TRAP: all enables 0, illegal=1. Holds until rst.
- take (combinational in BRANCH) by funct3: 000 Zero, 001 ~Zero, 100 Lt, 101 ~Lt, 110 Ltu, 111 ~Ltu.
- instr_done=1 in MEMWB, ALUWB, BRANCH, and MEMWRITE&rdy. instret increments on the same cycle.

## Timing

- Reset: the state register loads FETCH and instret loads 0. While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, and instr_done are forced to 0. illegal=0 after reset.
- Reset mid-instruction abandons that instruction; the next cycle is FETCH with no write issued.
- Cycle counts with zero wait: lw 5, sw 4, R/I 4, jal 4, branch 3. Each stalled memory cycle adds 1.
- Outputs are Moore functions of state. The only Mealy terms are rdy gating in FETCH/MEMREAD/MEMWRITE and take gating in BRANCH.
- instret wraps from 2^CNT_W-1 to 0 without a flag.

## Test plan

- rst=1 for 2 cycles, then add x3,x1,x2 (Op=0110011, f3=000, f7=0) -> state sequence FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000; RegWrite=1 only in cycle 4; instret=1.
- sub, then lw with mem_ready low for 2 cycles in MEMREAD -> ALUControl=001 in EXECUTER; lw takes 7 cycles; AdrSrc=1 held throughout MEMREAD.
- sw with MEM_WAIT=1 and 3 wait cycles -> MemWrite=1 for 4 consecutive cycles; instr_done pulses once.
- Branch sweep with BRANCH_FULL=1 over all 6 funct3 × flag combinations -> PCWrite in BRANCH equals the take table. With BRANCH_FULL=0, bne -> TRAP, illegal=1 held for 10 cycles, no enables asserted.
- Op=0110111 (lui) -> TRAP after DECODE; rst then returns the FSM to FETCH with illegal=0.
- CNT_W=4, 17 addi -> instret=1 after wrap; jal -> PCWrite high in FETCH and JAL, RegWrite in ALUWB.
